// File: rtl/traffic_pkg.sv
// Shared types, lamp codes and small helpers for the traffic-light sequencer.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_FLASH   = 2'd0,
        ST_GREEN   = 2'd1,
        ST_AMBER   = 2'd2,
        ST_ALL_RED = 2'd3
    } tl_state_t;

    typedef enum logic [1:0] {
        MODE_FLASH = 2'b00,
        MODE_AUTO  = 2'b01,
        MODE_EXT   = 2'b10
    } tl_mode_t;

    // Per-approach lamp code, {red, amber, green}
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_AMB = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Raw mode pins to mode; the unused 11 code falls back to flashing amber.
    function automatic tl_mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return MODE_AUTO;
            2'b10:   return MODE_EXT;
            default: return MODE_FLASH;
        endcase
    endfunction

    // Lamp code for one approach given the sequencer state and ownership of the phase.
    function automatic logic [2:0] lamp_of(input tl_state_t st, input logic owner,
                                           input logic blink);
        case (st)
            ST_FLASH: return blink ? LAMP_AMB : LAMP_OFF;
            ST_GREEN: return owner ? LAMP_GRN : LAMP_RED;
            ST_AMBER: return owner ? LAMP_AMB : LAMP_RED;
            default:  return LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second time base: free-running divider, one-cycle tick and a blink phase bit.
module sec_prescaler #(
    parameter int CLK_HZ = 27_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic sec_tick,
    output logic blink
);
    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, blink_q;
    logic          wrap;

    assign wrap = (cnt_q == CW'(CLK_HZ - 1));

    // Divider next value: wraps to zero after CLK_HZ-1
    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    // Counter, registered tick (high for the cycle after the wrap) and blink toggle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            blink_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= wrap;
            blink_q <= blink_q ^ wrap;
        end
    end

    assign sec_tick = tick_q;
    assign blink    = blink_q;

endmodule

// File: rtl/traffic_sequencer.sv
// Self-timed N-approach traffic sequencer: green -> amber -> all-red cycle,
// externally requested phases and flashing-amber mode, with registered lamp bus.
module traffic_sequencer
    import traffic_pkg::*;
#(
    parameter  int N_APPR   = 4,
    parameter  int CLK_HZ   = 27_000_000,
    parameter  int AMBER_S  = 3,
    parameter  int ALLRED_S = 1,
    parameter  int TW       = 8,
    localparam int PW       = (N_APPR > 1) ? $clog2(N_APPR) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic [TW-1:0]         green_len,
    input  logic                  ext_valid,
    input  logic [PW-1:0]         ext_phase,
    output logic [3*N_APPR-1:0]   semaforos,
    output logic [PW-1:0]         phase,
    output logic [1:0]            state_o,
    output logic                  sec_tick
);
    localparam int DW  = $clog2(((AMBER_S > ALLRED_S) ? AMBER_S : ALLRED_S) + 1);
    localparam int TMW = (TW > DW) ? TW : DW;
    localparam logic [TMW-1:0] AMBER_T  = TMW'(AMBER_S);
    localparam logic [TMW-1:0] ALLRED_T = TMW'(ALLRED_S);

    tl_state_t            state_q, state_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic [TMW-1:0]       timer_q, timer_d;
    logic                 first_q, first_d;       // next green goes to approach 0
    logic                 pend_valid_q, pend_valid_d;
    logic [PW-1:0]        pend_phase_q, pend_phase_d;
    logic [3*N_APPR-1:0]  lamps_q, lamps_d;

    logic                 tick, blink;
    tl_mode_t             mode_s;
    logic                 expire, green_done;
    logic [TMW-1:0]       green_load;
    logic [PW-1:0]        phase_inc;

    sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .sec_tick (tick),
        .blink    (blink)
    );

    assign mode_s     = decode_mode(mode);
    assign expire     = tick && (timer_q == TMW'(1));
    // Green has served its dwell once the timer expires; it then sits at zero while held.
    assign green_done = (timer_q == '0) || expire;
    assign green_load = (green_len == '0) ? TMW'(1) : TMW'(green_len);
    assign phase_inc  = (phase_q == PW'(N_APPR - 1)) ? '0 : phase_q + 1'b1;

    // Next-state decision for the phase FSM and dwell timer
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        timer_d = timer_q;
        first_d = first_q;
        if (tick && (timer_q != '0)) begin
            timer_d = timer_q - 1'b1;
        end
        case (state_q)
            ST_FLASH: begin
                if (mode_s != MODE_FLASH) begin
                    state_d = ST_ALL_RED;
                    timer_d = ALLRED_T;
                    phase_d = '0;
                    first_d = 1'b1;
                end
            end
            ST_GREEN: begin
                if (mode_s == MODE_FLASH) begin
                    state_d = ST_AMBER;
                    timer_d = AMBER_T;
                end else if (green_done && ((mode_s == MODE_AUTO) ||
                             (pend_valid_q && (pend_phase_q != phase_q)))) begin
                    state_d = ST_AMBER;
                    timer_d = AMBER_T;
                end
            end
            ST_AMBER: begin
                if (expire) begin
                    if (mode_s == MODE_FLASH) begin
                        state_d = ST_FLASH;
                    end else begin
                        state_d = ST_ALL_RED;
                        timer_d = ALLRED_T;
                    end
                end
            end
            default: begin
                if (mode_s == MODE_FLASH) begin
                    state_d = ST_FLASH;
                end else if (expire) begin
                    state_d = ST_GREEN;
                    timer_d = green_load;
                    first_d = 1'b0;
                    if ((mode_s == MODE_EXT) && pend_valid_q) begin
                        phase_d = pend_phase_q;
                    end else if (first_q) begin
                        phase_d = '0;
                    end else begin
                        phase_d = phase_inc;
                    end
                end
            end
        endcase
    end

    // Pending external target: latest in-range request wins; served or same-phase requests drop
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_phase_d = pend_phase_q;
        if ((state_q == ST_GREEN) && pend_valid_q && (pend_phase_q == phase_q)) begin
            pend_valid_d = 1'b0;
        end
        if (ext_valid && (int'(ext_phase) < N_APPR) &&
            !((state_q == ST_GREEN) && (ext_phase == phase_q))) begin
            pend_valid_d = 1'b1;
            pend_phase_d = ext_phase;
        end
    end

    // Lamp encoder from the current registered state; the lamp register lags state by one edge
    always_comb begin
        lamps_d = '0;
        for (int k = 0; k < N_APPR; k++) begin
            lamps_d[3*k +: 3] = lamp_of(state_q, phase_q == PW'(k), blink);
        end
    end

    // All sequencer state and the registered lamp bus
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FLASH;
            phase_q      <= '0;
            timer_q      <= '0;
            first_q      <= 1'b1;
            pend_valid_q <= 1'b0;
            pend_phase_q <= '0;
            lamps_q      <= {N_APPR{LAMP_AMB}};
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            timer_q      <= timer_d;
            first_q      <= first_d;
            pend_valid_q <= pend_valid_d;
            pend_phase_q <= pend_phase_d;
            lamps_q      <= lamps_d;
        end
    end

    assign semaforos = lamps_q;
    assign phase     = phase_q;
    assign state_o   = state_q;
    assign sec_tick  = tick;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Bench for traffic_sequencer with CLK_HZ=4: scoreboard of expected state segments
// (state, phase, dwell in cycles) checked on every state change, plus per-feature checks.
module tb_traffic_sequencer;

    localparam int CLK_HZ = 4;
    localparam logic [1:0] S_FL = 2'd0, S_G = 2'd1, S_A = 2'd2, S_AR = 2'd3;
    localparam logic [11:0] ALL_AMB = 12'b010_010_010_010;
    localparam logic [17:0] ALL_AMB6 = 18'b010_010_010_010_010_010;

    // ---------------- clock / reset block ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  mode = 2'b00;
    logic [7:0]  green_len = 8'd2;
    logic        ext_valid = 1'b0;
    logic [1:0]  ext_phase = 2'd0;
    logic [11:0] semaforos;
    logic [1:0]  phase;
    logic [1:0]  state_o;
    logic        sec_tick;

    logic        ext_valid6 = 1'b0;
    logic [2:0]  ext_phase6 = 3'd0;
    logic [17:0] semaforos6;
    logic [2:0]  phase6;
    logic [1:0]  state6;
    logic        sec_tick6;

    traffic_sequencer #(.N_APPR(4), .CLK_HZ(CLK_HZ), .AMBER_S(3), .ALLRED_S(1), .TW(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .green_len (green_len),
        .ext_valid (ext_valid),
        .ext_phase (ext_phase),
        .semaforos (semaforos),
        .phase     (phase),
        .state_o   (state_o),
        .sec_tick  (sec_tick)
    );

    traffic_sequencer #(.N_APPR(6), .CLK_HZ(CLK_HZ), .AMBER_S(3), .ALLRED_S(1), .TW(8)) u_dut6 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .green_len (green_len),
        .ext_valid (ext_valid6),
        .ext_phase (ext_phase6),
        .semaforos (semaforos6),
        .phase     (phase6),
        .state_o   (state6),
        .sec_tick  (sec_tick6)
    );

    // ---------------- scoreboard ----------------
    // entry = {state[11:10], phase[9:8], dwell_cycles[7:0]}; dwell 0 = not checked
    logic [11:0] exp_q[$];
    int compared = 0;
    int mismatched = 0;

    logic       mon_en = 1'b0;
    logic [1:0] last_st = 2'd0;
    logic       cur_valid = 1'b0;
    logic [1:0] cur_st = 2'd0;
    logic [1:0] cur_ph = 2'd0;
    int         cur_dur = 0;
    int         seg_len = 0;

    function automatic logic [11:0] exp_lamps(input logic [1:0] st, input logic [1:0] ph);
        logic [11:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            if (st == S_AR || k != int'(ph)) v[3*k +: 3] = 3'b100;
            else if (st == S_G)              v[3*k +: 3] = 3'b001;
            else                             v[3*k +: 3] = 3'b010;
        end
        return v;
    endfunction

    task automatic expect_seg(input logic [1:0] st, input logic [1:0] ph, input int dur);
        exp_q.push_back({st, ph, 8'(dur)});
    endtask

    // Advance to the next falling edge and run the scoreboard on state changes.
    task automatic step();
        logic [11:0] e;
        @(negedge clk);
        if (mon_en) begin
            if (state_o !== last_st) begin
                if (cur_valid && cur_dur != 0) begin
                    compared++;
                    if (seg_len != cur_dur) begin
                        mismatched++;
                        $display("FAIL dwell st=%0d ph=%0d: got %0d cycles, want %0d",
                                 cur_st, cur_ph, seg_len, cur_dur);
                    end
                end
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    cur_valid = 1'b0;
                    $display("FAIL unexpected transition: got st=%0d ph=%0d, want no change",
                             state_o, phase);
                end else begin
                    e = exp_q.pop_front();
                    cur_st = e[11:10];
                    cur_ph = e[9:8];
                    cur_dur = int'(e[7:0]);
                    cur_valid = 1'b1;
                    if ({state_o, phase} !== {cur_st, cur_ph}) begin
                        mismatched++;
                        $display("FAIL transition: got st=%0d ph=%0d, want st=%0d ph=%0d",
                                 state_o, phase, cur_st, cur_ph);
                    end
                end
                seg_len = 1;
            end else begin
                seg_len++;
            end
            if (cur_valid && seg_len == 2 && cur_st != S_FL) begin
                compared++;
                if (semaforos !== exp_lamps(cur_st, cur_ph)) begin
                    mismatched++;
                    $display("FAIL lamps st=%0d ph=%0d: got %b, want %b",
                             cur_st, cur_ph, semaforos, exp_lamps(cur_st, cur_ph));
                end
            end
        end
        last_st = state_o;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        exp_q.delete();
        cur_valid = 1'b0;
        ext_valid = 1'b0;
        ext_valid6 = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        last_st = state_o;
        mon_en = 1'b1;
    endtask

    task automatic drain_check(input string name);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s drain: got %0d expected transitions unseen, want 0", name, exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        mode = 2'b00;
        do_reset();
        compared++;
        if (state_o !== S_FL) begin mismatched++; $display("FAIL reset state: got %0d want 0", state_o); end
        compared++;
        if (phase !== 2'd0) begin mismatched++; $display("FAIL reset phase: got %0d want 0", phase); end
        compared++;
        if (semaforos !== ALL_AMB) begin mismatched++; $display("FAIL reset lamps: got %b want %b", semaforos, ALL_AMB); end
        compared++;
        if (sec_tick !== 1'b0) begin mismatched++; $display("FAIL reset tick: got %b want 0", sec_tick); end
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 4 || k == 5) begin
                compared++;
                if (sec_tick !== (k == 4)) begin
                    mismatched++;
                    $display("FAIL tick cycle %0d: got %b want %b", k, sec_tick, (k == 4));
                end
            end
            if (k % 4 == 2) begin
                compared++;
                if (semaforos !== ((((k - 1) / 4) % 2 == 0) ? ALL_AMB : 12'd0)) begin
                    mismatched++;
                    $display("FAIL flash blink cycle %0d: got %b want %b", k, semaforos,
                             ((((k - 1) / 4) % 2 == 0) ? ALL_AMB : 12'd0));
                end
            end
        end
    endtask

    task automatic test_auto();
        do_reset();
        mode = 2'b01;
        green_len = 8'd2;
        expect_seg(S_AR, 2'd0, 4);
        for (int p = 0; p < 4; p++) begin
            expect_seg(S_G,  2'(p), 8);
            expect_seg(S_A,  2'(p), 12);
            expect_seg(S_AR, 2'(p), 4);
        end
        expect_seg(S_G, 2'd0, 0);
        repeat (104) step();
        drain_check("auto");
        compared++;
        if ({state_o, phase} !== {S_G, 2'd0}) begin
            mismatched++;
            $display("FAIL auto wrap: got st=%0d ph=%0d want st=1 ph=0", state_o, phase);
        end
    endtask

    task automatic test_external();
        do_reset();
        mode = 2'b10;
        green_len = 8'd2;
        expect_seg(S_AR, 2'd0, 4);
        expect_seg(S_G,  2'd0, 8);
        expect_seg(S_A,  2'd0, 12);
        expect_seg(S_AR, 2'd0, 4);
        expect_seg(S_G,  2'd2, 34);
        expect_seg(S_A,  2'd2, 10);
        expect_seg(S_AR, 2'd2, 4);
        expect_seg(S_G,  2'd1, 0);
        repeat (6) step();
        ext_valid = 1'b1; ext_phase = 2'd3;
        step();
        ext_phase = 2'd2;
        step();
        ext_valid = 1'b0;
        repeat (32) step();
        compared++;
        if ({state_o, phase} !== {S_G, 2'd2}) begin
            mismatched++;
            $display("FAIL ext target: got st=%0d ph=%0d want st=1 ph=2", state_o, phase);
        end
        ext_valid = 1'b1; ext_phase = 2'd2;
        step();
        ext_valid = 1'b0;
        repeat (20) step();
        compared++;
        if ({state_o, phase} !== {S_G, 2'd2}) begin
            mismatched++;
            $display("FAIL ext same-phase hold: got st=%0d ph=%0d want st=1 ph=2", state_o, phase);
        end
        ext_valid = 1'b1; ext_phase = 2'd1;
        step();
        ext_valid = 1'b0;
        repeat (23) step();
        drain_check("external");
        compared++;
        if ({state_o, phase} !== {S_G, 2'd1}) begin
            mismatched++;
            $display("FAIL ext second target: got st=%0d ph=%0d want st=1 ph=1", state_o, phase);
        end
    endtask

    task automatic test_flash_entry();
        do_reset();
        mode = 2'b01;
        green_len = 8'd2;
        expect_seg(S_AR, 2'd0, 4);
        expect_seg(S_G,  2'd0, 2);
        expect_seg(S_A,  2'd0, 10);
        expect_seg(S_FL, 2'd0, 0);
        repeat (6) step();
        mode = 2'b00;
        repeat (14) step();
        drain_check("flash from green");
        compared++;
        if (state_o !== S_FL) begin mismatched++; $display("FAIL flash after amber: got %0d want 0", state_o); end
        mode = 2'b01;
        expect_seg(S_AR, 2'd0, 2);
        expect_seg(S_FL, 2'd0, 0);
        repeat (2) step();
        mode = 2'b11;
        repeat (4) step();
        drain_check("flash from all-red");
        compared++;
        if (state_o !== S_FL) begin mismatched++; $display("FAIL flash from all-red: got %0d want 0", state_o); end
    endtask

    task automatic test_green_zero_and_rst();
        do_reset();
        mode = 2'b01;
        green_len = 8'd0;
        expect_seg(S_AR, 2'd0, 4);
        expect_seg(S_G,  2'd0, 4);
        expect_seg(S_A,  2'd0, 12);
        expect_seg(S_AR, 2'd0, 4);
        expect_seg(S_G,  2'd1, 0);
        repeat (26) step();
        drain_check("green zero");
        compared++;
        if ({state_o, phase} !== {S_G, 2'd1}) begin
            mismatched++;
            $display("FAIL green zero phase: got st=%0d ph=%0d want st=1 ph=1", state_o, phase);
        end
        mon_en = 1'b0;
        rst = 1'b1;
        step();
        compared++;
        if ({state_o, phase, sec_tick} !== {S_FL, 2'd0, 1'b0}) begin
            mismatched++;
            $display("FAIL mid-green rst: got st=%0d ph=%0d tick=%b want st=0 ph=0 tick=0",
                     state_o, phase, sec_tick);
        end
        compared++;
        if (semaforos !== ALL_AMB) begin
            mismatched++;
            $display("FAIL mid-green rst lamps: got %b want %b", semaforos, ALL_AMB);
        end
        rst = 1'b0;
    endtask

    task automatic test_invalid_request();
        do_reset();
        mode = 2'b10;
        green_len = 8'd1;
        expect_seg(S_AR, 2'd0, 4);
        expect_seg(S_G,  2'd0, 0);
        repeat (10) step();
        compared++;
        if ({state6, phase6} !== {S_G, 3'd0}) begin
            mismatched++;
            $display("FAIL wide hold: got st=%0d ph=%0d want st=1 ph=0", state6, phase6);
        end
        ext_valid6 = 1'b1; ext_phase6 = 3'd6;
        step();
        ext_phase6 = 3'd7;
        step();
        ext_valid6 = 1'b0;
        repeat (20) step();
        compared++;
        if ({state6, phase6} !== {S_G, 3'd0}) begin
            mismatched++;
            $display("FAIL out-of-range ignored: got st=%0d ph=%0d want st=1 ph=0", state6, phase6);
        end
        ext_valid6 = 1'b1; ext_phase6 = 3'd5;
        step();
        ext_valid6 = 1'b0;
        repeat (20) step();
        compared++;
        if ({state6, phase6} !== {S_G, 3'd5}) begin
            mismatched++;
            $display("FAIL wide target 5: got st=%0d ph=%0d want st=1 ph=5", state6, phase6);
        end
        compared++;
        if (semaforos6 === ALL_AMB6) begin
            mismatched++;
            $display("FAIL wide lamps: got %b want not all-amber", semaforos6);
        end
        drain_check("invalid request");
    endtask

    initial begin
        test_reset();
        test_auto();
        test_external();
        test_flash_entry();
        test_green_zero_and_rst();
        test_invalid_request();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
